// File: rtl/addr_mode1_imm_encoder.sv
// Iterative ARM Addressing Mode 1 immediate encoder: one rotation tested per cycle.
// Define IMM_ENC_INVERT_EN to also search ~value (MVN/BIC form) after a failed direct search.
module addr_mode1_imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_value,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_found,
  output logic [11:0] resp_imm12,
  output logic        resp_carry,
  output logic        resp_inverted
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [3:0]  r_q, r_d;
  logic        found_q, found_d;
  logic [11:0] imm12_q, imm12_d;
  logic        carry_q, carry_d;

  logic [31:0] src;
  logic [4:0]  rot;
  logic [31:0] cand;
  logic        hit;
  logic        give_up;

`ifdef IMM_ENC_INVERT_EN
  logic p_q, p_d;
  logic inverted_q, inverted_d;
  assign src = p_q ? ~val_q : val_q;
`else
  assign src = val_q;
`endif

  // Left-rotate by 2*r; a shift of 32 yields zero, so r=0 passes src unchanged.
  assign rot  = {r_q, 1'b0};
  assign cand = (src << rot) | (src >> (6'd32 - {1'b0, rot}));
  assign hit  = (cand[31:8] == 24'd0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    r_d     = r_q;
    found_d = found_q;
    imm12_d = imm12_q;
    carry_d = carry_q;
    give_up = 1'b0;
`ifdef IMM_ENC_INVERT_EN
    p_d        = p_q;
    inverted_d = inverted_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          val_d   = req_value;
          r_d     = 4'd0;
`ifdef IMM_ENC_INVERT_EN
          p_d     = 1'b0;
`endif
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (hit) begin
          found_d = 1'b1;
          imm12_d = {r_q, cand[7:0]};
          carry_d = (r_q != 4'd0) & src[31];
`ifdef IMM_ENC_INVERT_EN
          inverted_d = p_q;
`endif
          state_d = StDone;
        end else if (r_q != 4'd15) begin
          r_d = r_q + 4'd1;
        end else begin
`ifdef IMM_ENC_INVERT_EN
          if (!p_q) begin
            p_d = 1'b1;
            r_d = 4'd0;
          end else begin
            give_up = 1'b1;
          end
`else
          give_up = 1'b1;
`endif
        end
        if (give_up) begin
          found_d = 1'b0;
          imm12_d = 12'd0;
          carry_d = 1'b0;
`ifdef IMM_ENC_INVERT_EN
          inverted_d = 1'b0;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val_q   <= 32'd0;
      r_q     <= 4'd0;
      found_q <= 1'b0;
      imm12_q <= 12'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      r_q     <= r_d;
      found_q <= found_d;
      imm12_q <= imm12_d;
      carry_q <= carry_d;
    end
  end

`ifdef IMM_ENC_INVERT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= 1'b0;
      inverted_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      inverted_q <= inverted_d;
    end
  end
  assign resp_inverted = inverted_q;
`else
  assign resp_inverted = 1'b0;
`endif

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_found = found_q;
  assign resp_imm12 = imm12_q;
  assign resp_carry = carry_q;

endmodule

// File: tb/tb_addr_mode1_imm_encoder.sv
// Directed bench for addr_mode1_imm_encoder; expectations follow IMM_ENC_INVERT_EN when defined.
module tb_addr_mode1_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_value = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_found;
  logic [11:0] resp_imm12;
  logic        resp_carry;
  logic        resp_inverted;

  int checks = 0;
  int errors = 0;

`ifdef IMM_ENC_INVERT_EN
  localparam int NoEncLat = 32;
  localparam logic InvOn = 1'b1;
`else
  localparam int NoEncLat = 16;
  localparam logic InvOn = 1'b0;
`endif

  addr_mode1_imm_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_value     (req_value),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_found    (resp_found),
    .resp_imm12    (resp_imm12),
    .resp_carry    (resp_carry),
    .resp_inverted (resp_inverted)
  );

  always #5 clk = ~clk;

  // Issues one request and returns edges from accept to resp_valid (41 on timeout).
  task automatic send(input logic [31:0] v, output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_wait req_ready stuck low value=%h", v);
    end
    req_valid = 1'b1;
    req_value = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat <= 40) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid === 1'b1) break;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted} !== 17'h10000)
    begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b f=%b imm=%h c=%b inv=%b want rdy=1 rest 0",
               req_ready, resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_direct();
    logic [31:0] vals[6];
    logic [11:0] imms[6];
    logic        cars[6];
    int          lats[6];
    int          lat;
    vals = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_000F, 32'h8000_0001, 32'h0000_03FC,
             32'h0000_0000};
    imms = '{12'h0FF, 12'h4FF, 12'h2FF, 12'h106, 12'hFFF, 12'h000};
    cars = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lats = '{1, 5, 3, 2, 16, 1};
    for (int i = 0; i < 6; i++) begin
      send(vals[i], lat);
      checks++;
      if (lat !== lats[i]) begin
        errors++;
        $display("FAIL direct_latency val=%h got %0d want %0d", vals[i], lat, lats[i]);
      end
      checks++;
      if ({resp_found, resp_imm12, resp_carry, resp_inverted} !== {1'b1, imms[i], cars[i], 1'b0})
      begin
        errors++;
        $display("FAIL direct_result val=%h got f=%b imm=%h c=%b inv=%b want f=1 imm=%h c=%b inv=0",
                 vals[i], resp_found, resp_imm12, resp_carry, resp_inverted, imms[i], cars[i]);
      end
      ack();
    end
  endtask

  task automatic test_no_encoding();
    int lat;
    send(32'h0000_0102, lat);
    checks++;
    if (lat !== NoEncLat) begin
      errors++;
      $display("FAIL noenc_latency got %0d want %0d", lat, NoEncLat);
    end
    checks++;
    if ({resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted} !== {1'b1, 15'd0}) begin
      errors++;
      $display("FAIL noenc_result got v=%b f=%b imm=%h c=%b inv=%b want v=1 f=0 imm=000 c=0 inv=0",
               resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted);
    end
    ack();
  endtask

  task automatic test_inverted();
    int lat;
    send(32'hFFFF_FF00, lat);
    checks++;
    if (lat !== (InvOn ? 17 : 16)) begin
      errors++;
      $display("FAIL inv_latency got %0d want %0d", lat, InvOn ? 17 : 16);
    end
    checks++;
    if ({resp_found, resp_imm12, resp_carry, resp_inverted} !==
        (InvOn ? {1'b1, 12'h0FF, 1'b0, 1'b1} : 15'd0)) begin
      errors++;
      $display("FAIL inv_result got f=%b imm=%h c=%b inv=%b want f=%b imm=%h c=0 inv=%b",
               resp_found, resp_imm12, resp_carry, resp_inverted, InvOn, InvOn ? 12'h0FF : 12'h0,
               InvOn);
    end
    ack();
  endtask

  task automatic test_stall();
    int lat;
    send(32'hFF00_0000, lat);
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 2);
      req_value = 32'h0000_00FF;
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, req_ready, resp_found, resp_imm12, resp_carry} !==
          {1'b1, 1'b0, 1'b1, 12'h4FF, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b f=%b imm=%h c=%b want v=1 rdy=0 f=1 imm=4ff c=1",
                 c, resp_valid, req_ready, resp_found, resp_imm12, resp_carry);
      end
    end
    req_valid = 1'b0;
    ack();
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_release got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    resp_ready = 1'b1;
    send(32'h0000_00FF, lat);
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid);
    end
    send(32'hF000_000F, lat);
    checks++;
    if (lat !== 3 || resp_imm12 !== 12'h2FF) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d imm=%h want lat=3 imm=2ff", lat, resp_imm12);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_search();
    int lat;
    req_valid = 1'b1;
    req_value = 32'h0000_0102;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted} !== 17'h10000)
    begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%b vld=%b f=%b imm=%h c=%b inv=%b want rdy=1 rest 0",
               req_ready, resp_valid, resp_found, resp_imm12, resp_carry, resp_inverted);
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0000, lat);
    checks++;
    if (lat !== 1 || {resp_found, resp_imm12, resp_carry} !== {1'b1, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL midreset_zero got lat=%0d f=%b imm=%h c=%b want lat=1 f=1 imm=000 c=0",
               lat, resp_found, resp_imm12, resp_carry);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_no_encoding();
    test_inverted();
    test_stall();
    test_back_to_back();
    // Leave a non-zero response registered so the mid-search reset clear is observable.
    test_stall();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
